// File: rtl/regfile_dump.sv
// ============================================================================
// Module   : regfile_dump
// Brief    : Walks a register range through a spare read port and streams
//            (index, data) words out on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump #(
  parameter int WIDTH     = 5,
  parameter int DATAWIDTH = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int ZERO_X0   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     rd_addr,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_idx,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [WIDTH-1:0] c_first   = WIDTH'(FIRST_REG);
  localparam logic [WIDTH-1:0] c_last    = WIDTH'(LAST_REG);
  localparam bit               c_zero_x0 = (ZERO_X0 != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_idx;
  logic [WIDTH-1:0]     w_idx_nxt;
  logic                 r_out_valid;
  logic                 w_out_valid_nxt;
  logic [WIDTH-1:0]     r_out_idx;
  logic [WIDTH-1:0]     w_out_idx_nxt;
  logic [DATAWIDTH-1:0] r_out_data;
  logic [DATAWIDTH-1:0] w_out_data_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_hs;

  assign w_hs = r_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= c_first;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_out_data  <= w_out_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_idx_nxt   = r_out_idx;
    w_out_data_nxt  = r_out_data;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (start) begin
          w_idx_nxt   = c_first;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        // x0 is architecturally zero; the port may return anything for it
        if (c_zero_x0 && (r_idx == '0)) begin
          w_out_data_nxt = '0;
        end else begin
          w_out_data_nxt = rd_data;
        end
        w_out_idx_nxt   = r_idx;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          w_out_valid_nxt = 1'b0;
          if (r_idx == c_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_READ;
          end
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  assign rd_addr   = r_idx;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

`default_nettype wire
